// File: rtl/ml_qpi_pkg.sv
// rtl/ml_qpi_pkg.sv - shared types and opcodes for the ml_* QPI responder
package ml_qpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RECV,
    DUMMY,
    SEND
  } state_t;

  localparam int         CMD_READ_BIT = 7;
  localparam logic [7:0] CMD_WRITE    = 8'h20;
  localparam logic [7:0] CMD_READ     = 8'h80;
  localparam logic [7:0] CMD_STATUS   = 8'h85;

  function automatic logic is_read_cmd(input logic [7:0] cmd);
    return cmd[CMD_READ_BIT];
  endfunction

endpackage

// File: rtl/ml_qpi_sync.sv
// rtl/ml_qpi_sync.sv - two-flop synchroniser and ml_clk edge detector
// Brings the host-driven QPI pins into the clk domain.
module ml_qpi_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ml_clk,
  input  logic       i_ml_csb,
  input  logic [3:0] i_ml_io,
  output logic       o_clk_rise,
  output logic       o_clk_fall,
  output logic       o_csb_s,
  output logic [3:0] o_io_s
);

  logic [2:0] r_clk_sync;
  logic [1:0] r_csb_sync;
  logic [3:0] r_io_s1;
  logic [3:0] r_io_s2;

  // csb flops come out of reset deasserted so no frame appears to start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_csb_sync <= 2'b11;
      r_io_s1    <= '0;
      r_io_s2    <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], i_ml_clk};
      r_csb_sync <= {r_csb_sync[0], i_ml_csb};
      r_io_s1    <= i_ml_io;
      r_io_s2    <= r_io_s1;
    end
  end

  assign o_clk_rise = r_clk_sync[1] & ~r_clk_sync[2];
  assign o_clk_fall = ~r_clk_sync[1] & r_clk_sync[2];
  assign o_csb_s    = r_csb_sync[1];
  assign o_io_s     = r_io_s2;

endmodule

// File: rtl/ml_qpi_target.sv
// rtl/ml_qpi_target.sv - QPI responder: oversampled deserialiser and read serialiser
// Host writes land on rx_*; read-class commands stream tx_data back nibble by nibble.
module ml_qpi_target
  import ml_qpi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ml_clk_in,
  input  logic       ml_csb_in,
  input  logic [3:0] ml_io_in,
  output logic [3:0] ml_io_out,
  output logic       ml_io_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy,
  input  logic       irq_in,
  input  logic       err_in,
  output logic       ml_irq,
  output logic       ml_err
);

  localparam logic [3:0] DUMMY_INIT = 4'(DUMMY_CYCLES);
  localparam bit         SKIP_DUMMY = (DUMMY_CYCLES == 0);

  logic       w_rise;
  logic       w_fall;
  logic       w_csb_s;
  logic [3:0] w_io_s;
  logic [7:0] w_byte;
  state_t     r_state;
  state_t     w_next_state;

  logic       r_phase;
  logic [3:0] r_hi;
  logic [3:0] r_lo;
  logic [3:0] r_cnt;
  logic [3:0] r_io_out;
  logic       r_rx_valid;
  logic       r_rx_first;
  logic [7:0] r_rx_data;
  logic       r_tx_ack;
  logic       r_irq;
  logic       r_err;
  logic       r_armed;
  logic [1:0] r_settle;

  ml_qpi_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_ml_clk   (ml_clk_in),
    .i_ml_csb   (ml_csb_in),
    .i_ml_io    (ml_io_in),
    .o_clk_rise (w_rise),
    .o_clk_fall (w_fall),
    .o_csb_s    (w_csb_s),
    .o_io_s     (w_io_s)
  );

  assign w_byte = {r_hi, w_io_s};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_csb_s) w_next_state = CMD;
      end
      CMD: begin
        if (w_rise && r_phase) begin
          if (!is_read_cmd(w_byte)) w_next_state = RECV;
          else if (SKIP_DUMMY)      w_next_state = SEND;
          else                      w_next_state = DUMMY;
        end
      end
      DUMMY: begin
        if (w_rise && r_cnt == 4'd1) w_next_state = SEND;
      end
      default: ;
    endcase
    if (r_state != IDLE && w_csb_s) w_next_state = IDLE;
  end

  // r_armed needs a genuine csb-high sample after the sync pipeline refills,
  // so a reset in mid-frame never rejoins that frame part-way through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_io_out   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_rx_data  <= '0;
      r_tx_ack   <= 1'b0;
      r_irq      <= 1'b0;
      r_err      <= 1'b0;
      r_armed    <= 1'b0;
      r_settle   <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_irq      <= irq_in;
      r_err      <= err_in;
      r_settle   <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_csb_s)  r_armed <= 1'b1;
      else if (r_state != IDLE)    r_armed <= 1'b0;
      if (r_state == IDLE) begin
        r_phase  <= 1'b0;
        r_io_out <= '0;
      end
      if (!w_csb_s) begin
        case (r_state)
          CMD, RECV: begin
            if (w_rise) begin
              if (!r_phase) begin
                r_hi <= w_io_s;
              end else begin
                r_rx_valid <= 1'b1;
                r_rx_first <= (r_state == CMD);
                r_rx_data  <= w_byte;
              end
              r_phase <= ~r_phase;
            end
          end
          DUMMY: begin
            if (w_rise) r_cnt <= r_cnt - 4'd1;
          end
          SEND: begin
            if (w_fall) begin
              if (!r_phase) begin
                r_lo     <= tx_data[3:0];
                r_io_out <= tx_data[7:4];
                r_tx_ack <= 1'b1;
              end else begin
                r_io_out <= r_lo;
              end
              r_phase <= ~r_phase;
            end
          end
          default: ;
        endcase
      end
      if (r_state == CMD && w_next_state == DUMMY) r_cnt <= DUMMY_INIT;
    end
  end

  assign ml_io_out = r_io_out;
  assign ml_io_oe  = (r_state == SEND);
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign rx_data   = r_rx_data;
  assign tx_ack    = r_tx_ack;
  assign busy      = (r_state != IDLE);
  assign ml_irq    = r_irq;
  assign ml_err    = r_err;

endmodule

// File: tb/tb_ml_qpi_target.sv
// tb/tb_ml_qpi_target.sv - frame-level bench for ml_qpi_target (DUMMY_CYCLES 2 and 0)
module tb_ml_qpi_target;
  import ml_qpi_pkg::*;

  typedef struct {
    int          sel;
    logic [7:0]  cmd;
    int          n;
    logic [31:0] data;
    int          cut;
    int          exp_rx_n;
    logic [47:0] exp_rx;
    int          exp_rd_n;
    logic [31:0] exp_rd;
    int          exp_ack;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ml_clk = 1'b0;
  logic       csb_a = 1'b1;
  logic       csb_b = 1'b1;
  logic [3:0] ml_io = 4'h0;
  logic       irq_in = 1'b0;
  logic       err_in = 1'b0;
  logic [7:0] tx_data;

  logic [3:0] io_out_a, io_out_b;
  logic       io_oe_a, io_oe_b, rx_valid_a, rx_valid_b, rx_first_a, rx_first_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       tx_ack_a, tx_ack_b, busy_a, busy_b;
  logic       ml_irq_a, ml_irq_b, ml_err_a, ml_err_b;
  logic [18:0] outs_a, outs_b;

  int         n_checks = 0;
  int         n_fail = 0;
  int         rx_total = 0;
  int         ack_total = 0;
  int         bad_first = 0;
  int         rx_base = 0;
  int         ack_base = 0;
  logic [8:0] rx_log [256];
  logic [7:0] tx_bytes [8];

  always #5 clk = ~clk;

  ml_qpi_target #(.DUMMY_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .ml_clk_in(ml_clk), .ml_csb_in(csb_a), .ml_io_in(ml_io),
    .ml_io_out(io_out_a), .ml_io_oe(io_oe_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .rx_first(rx_first_a), .tx_data(tx_data), .tx_ack(tx_ack_a), .busy(busy_a),
    .irq_in(irq_in), .err_in(err_in), .ml_irq(ml_irq_a), .ml_err(ml_err_a)
  );

  ml_qpi_target #(.DUMMY_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .ml_clk_in(ml_clk), .ml_csb_in(csb_b), .ml_io_in(ml_io),
    .ml_io_out(io_out_b), .ml_io_oe(io_oe_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .rx_first(rx_first_b), .tx_data(tx_data), .tx_ack(tx_ack_b), .busy(busy_b),
    .irq_in(irq_in), .err_in(err_in), .ml_irq(ml_irq_b), .ml_err(ml_err_b)
  );

  assign outs_a  = {io_oe_a, io_out_a, rx_valid_a, rx_first_a, rx_data_a, tx_ack_a, busy_a, ml_irq_a, ml_err_a};
  assign outs_b  = {io_oe_b, io_out_b, rx_valid_b, rx_first_b, rx_data_b, tx_ack_b, busy_b, ml_irq_b, ml_err_b};
  assign tx_data = tx_bytes[3'(ack_total - ack_base)];

  // core model: log every received byte, advance the tx pointer on each ack
  always @(negedge clk) begin
    if (rx_valid_a || rx_valid_b) begin
      rx_log[rx_total[7:0]] <= rx_valid_a ? {rx_first_a, rx_data_a} : {rx_first_b, rx_data_b};
      rx_total <= rx_total + 1;
    end
    if ((!rx_valid_a && rx_first_a) || (!rx_valid_b && rx_first_b)) bad_first <= bad_first + 1;
    if (tx_ack_a || tx_ack_b) ack_total <= ack_total + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_cycle(input int sel, input logic [3:0] nib, input bit do_fall,
                            output logic [3:0] got, output logic oe);
    ml_io = nib;
    repeat (4) @(negedge clk);
    got = (sel == 0) ? io_out_a : io_out_b;
    oe  = (sel == 0) ? io_oe_a : io_oe_b;
    ml_clk = 1'b1;
    repeat (4) @(negedge clk);
    if (do_fall) ml_clk = 1'b0;
  endtask

  function automatic vec_t model(input int sel, input logic [7:0] cmd, input int n,
                                 input logic [31:0] data, input int cut);
    vec_t v;
    int   total;
    v.sel = sel; v.cmd = cmd; v.n = n; v.data = data; v.cut = cut;
    v.exp_rx = {cmd, data, 8'h00};
    if (cmd[7]) begin
      v.exp_rx_n = 1; v.exp_rd_n = 2 * n; v.exp_rd = data; v.exp_ack = n;
    end else begin
      total = 2 + 2 * n;
      if (cut >= 0 && cut < total) total = cut;
      v.exp_rx_n = total / 2; v.exp_rd_n = 0; v.exp_rd = '0; v.exp_ack = 0;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [3:0] nibs [$];
    logic [3:0] got;
    logic       oe;
    int         rx_n;
    for (int i = 0; i < 8; i++) tx_bytes[i] = (i < v.n && i < 4) ? v.data[31-8*i -: 8] : 8'hEE;
    ack_base = ack_total;
    rx_base  = rx_total;
    nibs.push_back(v.cmd[7:4]);
    nibs.push_back(v.cmd[3:0]);
    if (!v.cmd[7]) for (int k = 0; k < 2 * v.n; k++) nibs.push_back(v.data[31-4*k -: 4]);
    if (v.sel == 0) csb_a = 1'b0; else csb_b = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nibs.size(); k++) begin
      if (v.cut >= 0 && k >= v.cut) break;
      host_cycle(v.sel, nibs[k], 1'b1, got, oe);
      check("oe_low_outside_send", oe, 1'b0);
      if (k == 0) check("busy_in_frame", (v.sel == 0) ? busy_a : busy_b, 1'b1);
    end
    if (v.exp_rd_n > 0) begin
      for (int k = 0; k < ((v.sel == 0) ? 2 : 0); k++) begin
        host_cycle(v.sel, 4'h0, 1'b1, got, oe);
        check("oe_low_in_dummy", oe, 1'b0);
      end
      for (int k = 0; k < v.exp_rd_n; k++) begin
        host_cycle(v.sel, 4'h0, k < v.exp_rd_n - 1, got, oe);
        check("oe_high_in_send", oe, 1'b1);
        check("read_nibble", got, v.exp_rd[31-4*k -: 4]);
      end
    end
    csb_a = 1'b1;
    csb_b = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_drop", (v.sel == 0) ? busy_a : busy_b, 1'b0);
    check("oe_drop", (v.sel == 0) ? io_oe_a : io_oe_b, 1'b0);
    ml_clk = 1'b0;
    repeat (6) @(negedge clk);
    rx_n = rx_total - rx_base;
    check("rx_count", rx_n, v.exp_rx_n);
    for (int i = 0; i < rx_n && i < v.exp_rx_n; i++)
      check("rx_byte", rx_log[(rx_base + i) & 255], {(i == 0), v.exp_rx[47-8*i -: 8]});
    check("tx_ack_count", ack_total - ack_base, v.exp_ack);
  endtask

  initial begin
    vec_t       tbl [6];
    vec_t       v;
    logic [3:0] got;
    logic       oe;
    logic       last_irq;
    logic       last_err;
    int         sel;
    int         n;
    int         cut;
    logic [7:0] cmd;

    tbl[0] = '{0, 8'h20, 2, 32'hA53C_0000, -1, 3, 48'h20A53C_000000, 0, 32'h0, 0};
    tbl[1] = '{0, 8'h85, 2, 32'h5AC3_0000, -1, 1, 48'h85_0000000000, 4, 32'h5AC3_0000, 2};
    tbl[2] = '{0, 8'h20, 1, 32'h7000_0000, 3, 1, 48'h20_0000000000, 0, 32'h0, 0};
    tbl[3] = '{0, 8'h40, 1, 32'h9B00_0000, -1, 2, 48'h409B_00000000, 0, 32'h0, 0};
    tbl[4] = '{1, 8'h80, 1, 32'hD200_0000, -1, 1, 48'h80_0000000000, 2, 32'hD200_0000, 1};
    tbl[5] = '{1, 8'h3E, 3, 32'h0112_FF00, -1, 4, 48'h3E0112FF_0000, 0, 32'h0, 0};
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;

    reset = 1'b1; irq_in = 1'b1; err_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", outs_a, 19'h0);
    check("reset_outputs_b", outs_b, 19'h0);
    irq_in = 1'b0; err_in = 1'b0; reset = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // irq/err follow with one cycle of latency while a write frame runs
    last_irq = 1'b0; last_err = 1'b0;
    fork
      run_vec(model(0, CMD_WRITE, 3, 32'hC0FF_EE00, -1));
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          if (i > 0) begin
            check("ml_irq_latency", {ml_irq_a, ml_irq_b}, {last_irq, last_irq});
            check("ml_err_latency", {ml_err_a, ml_err_b}, {last_err, last_err});
          end
          irq_in = (i % 2 == 0); err_in = (i % 3 == 0);
          last_irq = irq_in; last_err = err_in;
        end
        @(negedge clk);
        irq_in = 1'b0; err_in = 1'b0;
      end
    join

    // reset while the second read byte is on the wire
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
    ack_base = ack_total; rx_base = rx_total;
    csb_a = 1'b0;
    repeat (4) @(negedge clk);
    host_cycle(0, CMD_STATUS[7:4], 1'b1, got, oe);
    host_cycle(0, CMD_STATUS[3:0], 1'b1, got, oe);
    host_cycle(0, 4'h0, 1'b1, got, oe);
    host_cycle(0, 4'h0, 1'b1, got, oe);
    host_cycle(0, 4'h0, 1'b1, got, oe);
    check("rst_seq_nib0", got, 4'h1);
    host_cycle(0, 4'h0, 1'b1, got, oe);
    check("rst_seq_nib1", got, 4'h1);
    repeat (4) @(negedge clk);
    check("rst_seq_byte2_hi", {io_oe_a, io_out_a}, 5'h12);
    irq_in = 1'b1; err_in = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_send_outputs", outs_a, 19'h0);
    irq_in = 1'b0; err_in = 1'b0;
    for (int k = 0; k < 4; k++) host_cycle(0, (k % 2 == 0) ? 4'h2 : 4'h0, 1'b1, got, oe);
    check("rst_no_resync_busy", busy_a, 1'b0);
    check("rst_no_resync_rx", rx_total - rx_base, 1);
    csb_a = 1'b1;
    repeat (6) @(negedge clk);
    csb_a = 1'b0;
    repeat (4) @(negedge clk);
    host_cycle(0, 4'h2, 1'b1, got, oe);
    host_cycle(0, 4'h0, 1'b1, got, oe);
    csb_a = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_recover_rx", rx_total - rx_base, 2);
    check("rst_recover_byte", rx_log[(rx_base + 1) & 255], {1'b1, CMD_WRITE});

    for (int r = 0; r < 14; r++) begin
      sel = int'($urandom_range(0, 1));
      cmd = 8'($urandom);
      n   = int'($urandom_range(1, 4));
      cut = -1;
      if (!cmd[7] && $urandom_range(0, 2) == 0) cut = int'($urandom_range(1, 2 * n + 1));
      v = model(sel, cmd, n, $urandom, cut);
      run_vec(v);
    end

    check("rx_first_only_with_valid", bad_first, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ml_qpi_target.md
Name: ml_qpi_target

Overview:
- Responder end of the ml_* QPI link that the control SoC drives: ml_clk/ml_csb/ml_io[3:0] from the host, ml_irq/ml_err back to it.
- Oversamples the host-driven signals in the local clk domain.
- Deserialises command and write bytes into a byte stream for the accelerator core.
- Serialises core-supplied bytes back to the host for read-class commands.

Parameters:
DUMMY_CYCLES, 2, ml_clk rising edges between the command byte and the first read nibble (0..15)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ml_clk_in  in  1  host QPI clock, asynchronous to clk
ml_csb_in  in  1  host chip select, active low, asynchronous
ml_io_in  in  4  host data nibble, asynchronous
ml_io_out  out  4  responder data nibble
ml_io_oe  out  1  output enable for ml_io
rx_valid  out  1  one-cycle strobe: rx_data holds a received byte
rx_data  out  8  received byte
rx_first  out  1  qualifies rx_valid: byte is the command byte
tx_data  in  8  next byte to send; must be stable from tx_ack until the next byte load
tx_ack  out  1  one-cycle strobe: tx_data has been latched, core advances
busy  out  1  high while a transaction is open
irq_in  in  1  core interrupt request
err_in  in  1  core error flag
ml_irq  out  1  registered copy of irq_in
ml_err  out  1  registered copy of err_in

Behaviour:
- Reset values: all outputs 0, ml_io_out=0, state=IDLE, sync flops cleared; ml_csb sync flops reset to 1.
- Sync: ml_clk_in, ml_csb_in and ml_io_in each pass through 2 flops. A third ml_clk flop gives edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The io nibble is sampled from its s2 stage on rise.
- Timing requirement: ml_clk period >= 8 clk cycles, each phase >= 4 clk.
  - Output nibble changes at most 4 clk after a host falling edge.
- States: IDLE, CMD, RECV, DUMMY, SEND; busy = (state != IDLE).
- csb override: synced csb high forces IDLE the next cycle from any state.
  - ml_io_oe drops in that same cycle.
  - A partial byte is discarded with no rx_valid.
  - csb priority beats a simultaneous edge.
- IDLE -> CMD: on synced csb low; nibble phase cleared.
- CMD: rise with phase 0 stores the high nibble. Rise with phase 1 completes the byte:
  - rx_valid=1, rx_first=1, rx_data=byte in the next cycle.
  - Command bit7=1 is read-class: go to DUMMY with counter=DUMMY_CYCLES, or straight to SEND if DUMMY_CYCLES=0.
  - Command bit7=0: go to RECV.
- RECV: every two rises emit rx_valid with rx_first=0, high nibble first. Unlimited length.
  - There is no backpressure; the consumer accepts every strobe.
- DUMMY: each rise decrements the counter; the rise that reaches 0 enters SEND. io is not sampled.
- SEND: ml_io_oe=1 for the whole state.
  - Fall with phase 0: latch tx_data into the shift register, drive bits [7:4], pulse tx_ack the next cycle.
  - Fall with phase 1: drive bits [3:0].
  - Phase toggles on each fall; rises are ignored.
  - The first fall after entering SEND is phase 0.
- rx_first is 0 whenever rx_valid is 0. rx_data holds its value between strobes.
- ml_irq and ml_err are single-flop registered copies of irq_in and err_in, independent of state.
- Reset mid-transaction: returns to IDLE and drops ml_io_oe the next cycle. The block waits for csb high before accepting a new CMD, so it never resynchronises mid-frame.

Decomposition:
- Shared package ml_qpi_pkg holds:
  - the state enum;
  - CMD_READ_BIT = 7;
  - example opcodes: CMD_WRITE = 8'h20, CMD_READ = 8'h80, CMD_STATUS = 8'h85.
- One natural sub-module: ml_qpi_sync, the 2-flop synchroniser plus edge detector producing clk_rise, clk_fall, csb_s and io_s.

Test Plan:
- Write frame, clk/ml_clk = 8: csb low, nibbles 2,0,A,5,3,C, csb high -> rx_valid x3.
  - Bytes 0x20 (rx_first=1), 0xA5, 0x3C; busy falls within 4 clk of csb rise.
- Read frame, DUMMY_CYCLES=2: command 0x85, 2 dummy clocks, tx_data=0x5A then 0xC3 -> host samples nibbles 5,A,C,3.
  - tx_ack pulses twice; ml_io_oe=1 only in SEND.
- Abort: csb rises after 3 nibbles (0x20 then 0x7) -> only the 0x20 strobe; no second rx_valid; next frame with command 0x40 decodes cleanly.
- Reset mid-SEND: assert reset during the second data byte -> ml_io_oe=0 and all outputs 0 the next cycle.
  - With csb still low, no rx_valid is produced until csb high then low.
- DUMMY_CYCLES=0 with command 0x80 -> first fall after the command drives tx_data[7:4], no gap.
- irq_in/err_in toggled during an active frame -> ml_irq/ml_err follow with 1-cycle latency; the data stream is unaffected.
